heater_array: RTL and testbench

HEATER_ARRAY -- requirements
Module: heater_array

---
 rtl/heater_pkg.sv | 23 ++
 rtl/heater_bank.sv | 26 ++
 rtl/heater_array.sv | 158 +++++++++++++++
 tb/tb_heater_array.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heater_pkg.sv
// Shared heater types: operating mode encoding and PATTERN FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package heater_pkg;

    localparam logic [1:0] MODE_ENC_OFF     = 2'd0;
    localparam logic [1:0] MODE_ENC_CONST   = 2'd1;
    localparam logic [1:0] MODE_ENC_PWM     = 2'd2;
    localparam logic [1:0] MODE_ENC_PATTERN = 2'd3;

    typedef enum logic [1:0] {
        MODE_OFF     = MODE_ENC_OFF,
        MODE_CONST   = MODE_ENC_CONST,
        MODE_PWM     = MODE_ENC_PWM,
        MODE_PATTERN = MODE_ENC_PATTERN
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/heater_bank.sv
// One heater bank: WIDTH toggle flops that all invert when enabled.
// Latency: toggles on the clock edge after en_i is sampled high.
// Backpressure: none; flops are kept so the thermal load survives synthesis.
module heater_bank #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] load_o
);

    (* keep = "true" *) logic [WIDTH-1:0] load_q;

    // Invert every flop of the bank on each enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q <= '0;
        end else if (en_i) begin
            load_q <= ~load_q;
        end
    end

    assign load_o = load_q;

endmodule

// File: rtl/heater_array.sv
// Heater array: CONST/PWM/PATTERN heat control driving maskable toggle banks.
// Latency: heating_active is registered, one cycle after the controlling inputs.
// Backpressure: PATTERN bytes accepted only when tx_ready (IDLE, enabled, PATTERN).
module heater_array
    import heater_pkg::*;
#(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned BANK_WIDTH = 64,
    parameter int unsigned CNT_W      = 64,
    parameter int unsigned PERIOD_W   = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            heating_enable,
    input  logic [1:0]                      mode,
    input  logic [NUM_BANKS-1:0]            bank_mask,
    input  logic [PERIOD_W-1:0]             period,
    input  logic [PERIOD_W-1:0]             duty,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    input  logic [7:0]                      tx_data,
    input  logic                            cnt_clear,
    output logic                            heating_active,
    output logic [CNT_W-1:0]                heating_counter_value,
    output logic [NUM_BANKS*BANK_WIDTH-1:0] heat_load
);

    localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

    mode_e                mode_s;
    logic                 pat_sel;
    logic                 pwm_sel;
    logic [PERIOD_W-1:0]  eff_period;
    logic                 bit_last;

    logic                 arm_q;
    logic                 active_q, active_d;
    logic [PERIOD_W-1:0]  phase_q, phase_d;
    state_e               state_q, state_d;
    logic [7:0]           byte_q, byte_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [PERIOD_W-1:0]  bit_tmr_q, bit_tmr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    assign mode_s     = mode_e'(mode);
    assign pat_sel    = heating_enable && (mode_s == MODE_PATTERN);
    assign pwm_sel    = heating_enable && (mode_s == MODE_PWM);
    // A zero PATTERN bit time behaves as a single cycle per bit.
    assign eff_period = (period == '0) ? ONE_P : period;
    assign bit_last   = (bit_tmr_q >= eff_period - ONE_P);

    // PWM phase free-runs 0..period-1 only while PWM is selected; otherwise parked at 0.
    always_comb begin
        phase_d = '0;
        if (pwm_sel && (period != '0) && (phase_q < period - ONE_P)) begin
            phase_d = phase_q + ONE_P;
        end
    end

    // PATTERN FSM: accept a byte in IDLE, shift it out MSB first, abort when deselected.
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        bit_idx_d = bit_idx_q;
        bit_tmr_d = bit_tmr_q;
        tx_ready  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_ready  = arm_q && pat_sel;
                bit_idx_d = 3'd7;
                bit_tmr_d = '0;
                if (tx_valid && tx_ready) begin
                    state_d = ST_SEND;
                    byte_d  = tx_data;
                end
            end
            ST_SEND: begin
                if (!pat_sel) begin
                    state_d   = ST_IDLE;
                    byte_d    = '0;
                    bit_idx_d = 3'd7;
                    bit_tmr_d = '0;
                end else if (bit_last) begin
                    bit_tmr_d = '0;
                    if (bit_idx_q == 3'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q - 3'd1;
                    end
                end else begin
                    bit_tmr_d = bit_tmr_q + ONE_P;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next heat-on decision from the selected mode; disabled means off.
    always_comb begin
        active_d = 1'b0;
        if (heating_enable) begin
            unique case (mode_s)
                MODE_CONST:   active_d = 1'b1;
                MODE_PWM:     active_d = (period != '0) && (phase_q < duty);
                MODE_PATTERN: active_d = (state_q == ST_SEND) && byte_q[bit_idx_q];
                default:      active_d = 1'b0;
            endcase
        end
    end

    // Saturating heat-cycle counter; a clear overrides a simultaneous increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (active_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; arm_q holds tx_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q     <= 1'b0;
            active_q  <= 1'b0;
            phase_q   <= '0;
            state_q   <= ST_IDLE;
            byte_q    <= '0;
            bit_idx_q <= 3'd7;
            bit_tmr_q <= '0;
            cnt_q     <= '0;
        end else begin
            arm_q     <= 1'b1;
            active_q  <= active_d;
            phase_q   <= phase_d;
            state_q   <= state_d;
            byte_q    <= byte_d;
            bit_idx_q <= bit_idx_d;
            bit_tmr_q <= bit_tmr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign heating_active        = active_q;
    assign heating_counter_value = cnt_q;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        heater_bank #(
            .WIDTH (BANK_WIDTH)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (active_q && bank_mask[g]),
            .load_o (heat_load[g*BANK_WIDTH +: BANK_WIDTH])
        );
    end

endmodule

// File: tb/tb_heater_array.sv
module tb_heater_array;
    import heater_pkg::*;

    localparam int NB = 4;
    localparam int BW = 8;
    localparam int CW = 8;
    localparam int PW = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           heating_enable;
    logic [1:0]     mode;
    logic [NB-1:0]  bank_mask;
    logic [PW-1:0]  period;
    logic [PW-1:0]  duty;
    logic           tx_valid;
    logic           tx_ready;
    logic [7:0]     tx_data;
    logic           cnt_clear;
    logic           heating_active;
    logic [CW-1:0]  heating_counter_value;
    logic [NB*BW-1:0] heat_load;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: expected counter, last expected heat bit, bank parities.
    int          exp_cnt;
    bit          prev_act;
    bit [NB-1:0] bank_par;

    typedef struct {
        logic [PW-1:0] per;
        logic [PW-1:0] dty;
        int            cycles;
        int            ones;
    } pwm_vec_t;

    pwm_vec_t vecs [8];

    always #5 clk = ~clk;

    heater_array #(
        .NUM_BANKS  (NB),
        .BANK_WIDTH (BW),
        .CNT_W      (CW),
        .PERIOD_W   (PW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .heating_enable        (heating_enable),
        .mode                  (mode),
        .bank_mask             (bank_mask),
        .period                (period),
        .duty                  (duty),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .tx_data               (tx_data),
        .cnt_clear             (cnt_clear),
        .heating_active        (heating_active),
        .heating_counter_value (heating_counter_value),
        .heat_load             (heat_load)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [NB*BW-1:0] expand_load(input bit [NB-1:0] p);
        logic [NB*BW-1:0] r;
        r = '0;
        for (int b = 0; b < NB; b++) begin
            if (p[b]) r[b*BW +: BW] = '1;
        end
        return r;
    endfunction

    function automatic void model_reset();
        exp_cnt  = 0;
        prev_act = 1'b0;
        bank_par = '0;
    endfunction

    // One clock: advance the model for this edge, then compare all outputs.
    task automatic step(input bit exp_act);
        if (cnt_clear) exp_cnt = 0;
        else if (prev_act && exp_cnt < (1 << CW) - 1) exp_cnt++;
        for (int b = 0; b < NB; b++) begin
            if (prev_act && bank_mask[b]) bank_par[b] = ~bank_par[b];
        end
        prev_act = exp_act;
        @(posedge clk);
        #1;
        check("heating_active", heating_active, exp_act);
        check("counter", heating_counter_value, exp_cnt);
        check("heat_load", heat_load, expand_load(bank_par));
    endtask

    task automatic idle_clear();
        mode      = MODE_OFF;
        tx_valid  = 1'b0;
        cnt_clear = 1'b1;
        step(1'b0);
        cnt_clear = 1'b0;
    endtask

    // Send one byte and expect each bit held for max(period,1) cycles, MSB first.
    task automatic send_byte(input logic [7:0] d, input int per_in);
        int p;
        p = (per_in == 0) ? 1 : per_in;
        mode           = MODE_PATTERN;
        heating_enable = 1'b1;
        period         = PW'(per_in);
        tx_data        = d;
        tx_valid       = 1'b1;
        #1;
        check("tx_ready_idle", tx_ready, 1'b1);
        step(1'b0);
        tx_valid = 1'b0;
        #1;
        check("tx_ready_accept", tx_ready, 1'b0);
        for (int j = 0; j < 8 * p; j++) begin
            step(d[7 - j / p]);
            check("tx_ready_send", tx_ready, (j == 8 * p - 1));
        end
        step(1'b0);
    endtask

    initial begin
        vecs[0] = '{per: 4, dty: 1, cycles: 16, ones: 4};
        vecs[1] = '{per: 4, dty: 0, cycles: 16, ones: 0};
        vecs[2] = '{per: 4, dty: 5, cycles: 16, ones: 16};
        vecs[3] = '{per: 0, dty: 3, cycles: 8,  ones: 0};
        vecs[4] = '{per: 3, dty: 2, cycles: 9,  ones: 6};
        vecs[5] = '{per: 1, dty: 1, cycles: 5,  ones: 5};
        vecs[6] = '{per: 5, dty: 2, cycles: 10, ones: 4};
        vecs[7] = '{per: 2, dty: 2, cycles: 6,  ones: 6};

        // Reset with PATTERN already selected: tx_ready must wait for a clock edge.
        rst_n          = 1'b0;
        heating_enable = 1'b1;
        mode           = MODE_PATTERN;
        bank_mask      = '0;
        period         = '0;
        duty           = '0;
        tx_valid       = 1'b0;
        tx_data        = '0;
        cnt_clear      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_active", heating_active, 1'b0);
        check("rst_ready", tx_ready, 1'b0);
        check("rst_counter", heating_counter_value, 0);
        check("rst_load", heat_load, 0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", tx_ready, 1'b0);
        step(1'b0);
        check("ready_after_edge", tx_ready, 1'b1);

        // CONST on banks 0 and 2 for ten cycles.
        idle_clear();
        bank_mask      = 4'b0101;
        mode           = MODE_CONST;
        heating_enable = 1'b1;
        for (int k = 0; k < 10; k++) step(1'b1);
        heating_enable = 1'b0;
        step(1'b0);
        check("const_counter", heating_counter_value, 10);
        check("const_load", heat_load, 0);

        // PWM boundary table.
        bank_mask = 4'b1111;
        for (int v = 0; v < 8; v++) begin
            int ones;
            int pp;
            idle_clear();
            mode           = MODE_PWM;
            heating_enable = 1'b1;
            period         = vecs[v].per;
            duty           = vecs[v].dty;
            pp             = int'(vecs[v].per);
            ones           = 0;
            for (int k = 0; k < vecs[v].cycles; k++) begin
                step((pp != 0) && ((k % (pp == 0 ? 1 : pp)) < int'(vecs[v].dty)));
                ones += int'(heating_active);
            end
            check("pwm_ones", ones, vecs[v].ones);
            mode = MODE_OFF;
            step(1'b0);
            check("pwm_counter", heating_counter_value, vecs[v].ones);
        end

        // PATTERN 0xA5 with 3-cycle bits.
        idle_clear();
        send_byte(8'hA5, 3);
        check("a5_counter", heating_counter_value, 12);

        // PATTERN with zero bit time behaves as one cycle per bit.
        idle_clear();
        send_byte(8'h96, 0);

        // Enable dropped mid-byte: abort to IDLE, no resumption.
        idle_clear();
        mode           = MODE_PATTERN;
        heating_enable = 1'b1;
        period         = 2;
        tx_data        = 8'hFF;
        tx_valid       = 1'b1;
        step(1'b0);
        tx_valid = 1'b0;
        for (int k = 0; k < 5; k++) step(1'b1);
        heating_enable = 1'b0;
        step(1'b0);
        check("abort_counter", heating_counter_value, 5);
        heating_enable = 1'b1;
        #1;
        check("abort_idle_ready", tx_ready, 1'b1);
        step(1'b0);

        // Saturation and clear-wins.
        idle_clear();
        mode = MODE_CONST;
        for (int k = 0; k < 300; k++) step(1'b1);
        check("sat_counter", heating_counter_value, 255);
        cnt_clear = 1'b1;
        step(1'b1);
        check("clear_wins", heating_counter_value, 0);
        cnt_clear = 1'b0;
        step(1'b1);
        check("after_clear", heating_counter_value, 1);

        // Reset mid-SEND, then a clean byte from bit 7.
        idle_clear();
        mode     = MODE_PATTERN;
        period   = 2;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        step(1'b0);
        tx_valid = 1'b0;
        step(1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_active", heating_active, 1'b0);
        check("midrst_ready", tx_ready, 1'b0);
        check("midrst_counter", heating_counter_value, 0);
        check("midrst_load", heat_load, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_ready_release", tx_ready, 1'b0);
        step(1'b0);
        send_byte(8'h5A, 1);

        // Randomized segments, each preceded by an OFF cycle.
        for (int s = 0; s < 40; s++) begin
            int m;
            int pp;
            int dd;
            int len;
            bit en;
            m         = $urandom_range(0, 3);
            en        = ($urandom_range(0, 4) != 0);
            pp        = $urandom_range(0, 6);
            dd        = $urandom_range(0, 7);
            len       = $urandom_range(1, 20);
            mode      = MODE_OFF;
            bank_mask = NB'($urandom);
            cnt_clear = ($urandom_range(0, 7) == 0);
            step(1'b0);
            cnt_clear = 1'b0;
            if (m == 3 && en) begin
                send_byte(8'($urandom), pp);
            end else begin
                mode           = 2'(m);
                heating_enable = en;
                period         = PW'(pp);
                duty           = PW'(dd);
                for (int k = 0; k < len; k++) begin
                    step(en && ((m == 1) ||
                                (m == 2 && pp != 0 && (k % (pp == 0 ? 1 : pp)) < dd)));
                end
            end
            heating_enable = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
